// File: rtl/ice51_pkg.sv
// rtl/ice51_pkg.sv - shared ice51 constants and UART receive state encodings
package ice51_pkg;

    localparam int UART_CLKS_PER_BIT = 104;
    localparam int CODE_MEM_SIZE     = 512;
    localparam int CODE_ADDR_W       = 9;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ice51_uart_rx.sv
// rtl/ice51_uart_rx.sv - 8N1 UART receiver with input synchroniser, one-cycle byte/frame-error pulses
module ice51_uart_rx
    import ice51_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    // Preset to idle-high so a reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ice51_uart_loader.sv
// rtl/ice51_uart_loader.sv - streams a UART program image into code memory, then releases the core
module ice51_uart_loader
    import ice51_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int MEM_SIZE     = CODE_MEM_SIZE,
    parameter int ADDR_W       = CODE_ADDR_W,
    parameter int PRELOAD      = 0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_uart_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_nrst,
    output logic              o_frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] load_ptr;
    logic              load_full;

    ice51_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_rx        (i_uart_rx),
        .o_valid     (rx_valid),
        .o_data      (rx_data),
        .o_frame_err (o_frame_err)
    );

    // load_full blocks any byte landing between the last write and the core release.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_nrst  <= (PRELOAD != 0);
            load_ptr    <= '0;
            load_full   <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            if (rx_valid && !o_cpu_nrst && !load_full) begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= load_ptr;
                o_mem_wdata <= rx_data;
                if (load_ptr == LAST_ADDR) begin
                    load_full <= 1'b1;
                end else begin
                    load_ptr <= load_ptr + 1'b1;
                end
            end
            if (o_mem_we && (o_mem_addr == LAST_ADDR)) begin
                o_cpu_nrst <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ice51_uart_loader.sv
// tb/tb_ice51_uart_loader.sv - directed self-checking bench for ice51_uart_loader
module tb_ice51_uart_loader;

    localparam int CPB = 10;
    localparam int MSZ = 512;
    localparam int AW  = 9;

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic          rx   = 1'b1;
    logic          mem_we, cpu_nrst, frame_err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we2, cpu_nrst2, frame_err2;
    logic [AW-1:0] mem_addr2;
    logic [7:0]    mem_wdata2;

    always #5 clk = ~clk;

    ice51_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MSZ), .ADDR_W(AW), .PRELOAD(0)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_uart_rx   (rx),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_nrst  (cpu_nrst),
        .o_frame_err (frame_err)
    );

    ice51_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MSZ), .ADDR_W(AW), .PRELOAD(1)) dut_pre (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_uart_rx   (rx),
        .o_mem_we    (mem_we2),
        .o_mem_addr  (mem_addr2),
        .o_mem_wdata (mem_wdata2),
        .o_cpu_nrst  (cpu_nrst2),
        .o_frame_err (frame_err2)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fe_cnt = 0, fe2_cnt = 0, we2_cnt = 0;
    int   last_we_cyc = -1, rise_cyc = -2;
    logic prev_nrst = 1'b0;
    int   wa[$], wd[$], wn[$];

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wdata));
            wn.push_back(int'(cpu_nrst));
            if (mem_addr == AW'(MSZ - 1)) last_we_cyc = cyc;
        end
        if (frame_err)  fe_cnt++;
        if (frame_err2) fe2_cnt++;
        if (mem_we2)    we2_cnt++;
        if (cpu_nrst && !prev_nrst) rise_cyc = cyc;
        prev_nrst = cpu_nrst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    initial begin
        int base;
        int f0;
        int nerr;
        int early;

        nrst = 1'b0;
        rx   = 1'b1;
        idle(3);
        chk("rst_mem_we",      mem_we,    1'b0);
        chk("rst_mem_addr",    mem_addr,  '0);
        chk("rst_mem_wdata",   mem_wdata, 8'h00);
        chk("rst_frame_err",   frame_err, 1'b0);
        chk("rst_cpu_nrst",    cpu_nrst,  1'b0);
        chk("rst_cpu_nrst_pre", cpu_nrst2, 1'b1);
        nrst = 1'b1;
        idle(5);
        chk("pre_cpu_nrst_out_of_reset", cpu_nrst2, 1'b1);

        base = wa.size();
        send_byte(8'hA5, 1'b1);
        idle(3 * CPB);
        chk("a5_count",    wa.size() - base, 1);
        chk("a5_addr",     wa[base], 0);
        chk("a5_data",     wd[base], 32'hA5);
        chk("a5_cpu_nrst", cpu_nrst, 1'b0);

        base = wa.size();
        f0   = fe_cnt;
        send_byte(8'h3C, 1'b0);
        idle(3 * CPB);
        chk("ferr_pulses", fe_cnt - f0, 1);
        chk("ferr_no_write", wa.size() - base, 0);
        send_byte(8'h11, 1'b1);
        idle(3 * CPB);
        chk("after_ferr_count", wa.size() - base, 1);
        chk("after_ferr_addr",  wa[base], 1);
        chk("after_ferr_data",  wd[base], 32'h11);

        base = wa.size();
        f0   = fe_cnt;
        rx   = 1'b0;
        idle(3);
        rx   = 1'b1;
        idle(3 * CPB);
        chk("glitch_no_write", wa.size() - base, 0);
        chk("glitch_no_ferr",  fe_cnt - f0, 0);
        send_byte(8'h5A, 1'b1);
        idle(3 * CPB);
        chk("post_glitch_addr", wa[base], 2);
        chk("post_glitch_data", wd[base], 32'h5A);

        send_byte(8'h03, 1'b1);
        idle(3 * CPB);
        send_byte(8'h04, 1'b1);
        idle(3 * CPB);
        chk("pre_rst_addr",  mem_addr,  AW'(4));
        chk("pre_rst_wdata", mem_wdata, 8'h04);

        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        rx = 1'b0;
        idle(CPB / 2);
        nrst = 1'b0;
        #1;
        chk("midrst_mem_we",    mem_we,    1'b0);
        chk("midrst_mem_addr",  mem_addr,  '0);
        chk("midrst_mem_wdata", mem_wdata, 8'h00);
        chk("midrst_cpu_nrst",  cpu_nrst,  1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        idle(2);
        rx = 1'b1;
        idle(2 * CPB);
        nrst = 1'b1;
        idle(5);

        base = wa.size();
        for (int i = 0; i < MSZ; i++) begin
            send_byte(8'(i), 1'b1);
        end
        idle(3 * CPB);
        chk("stream_count", wa.size() - base, MSZ);
        nerr  = 0;
        early = 0;
        for (int i = 0; i < MSZ; i++) begin
            if (wa[base + i] != i || wd[base + i] != (i & 32'hFF)) nerr++;
            if (wn[base + i] != 0) early++;
        end
        chk("stream_order_errors", nerr, 0);
        chk("stream_first_addr",   wa[base], 0);
        chk("stream_last_addr",    wa[base + MSZ - 1], MSZ - 1);
        chk("stream_last_data",    wd[base + MSZ - 1], 32'hFF);
        chk("stream_early_release", early, 0);
        chk("release_latency",     rise_cyc - last_we_cyc, 1);
        chk("done_cpu_nrst",       cpu_nrst, 1'b1);

        base = wa.size();
        f0   = fe_cnt;
        send_byte(8'hFF, 1'b1);
        idle(3 * CPB);
        chk("post_done_no_write", wa.size() - base, 0);
        chk("post_done_cpu_nrst", cpu_nrst, 1'b1);
        send_byte(8'h3C, 1'b0);
        idle(3 * CPB);
        chk("post_done_ferr",      fe_cnt - f0, 1);
        chk("post_done_no_write2", wa.size() - base, 0);
        chk("post_done_cpu_nrst2", cpu_nrst, 1'b1);

        chk("pre_no_writes",  we2_cnt, 0);
        chk("pre_cpu_nrst",   cpu_nrst2, 1'b1);
        chk("pre_ferr_count", fe2_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
